// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_seq_pkg;

    typedef enum logic [1:0] {StIdle, StCfg, StStream, StDrain} seq_state_e;

    localparam int unsigned CFG_NFFT_LSB = 0;
    localparam int unsigned CFG_NFFT_W   = 5;
    localparam int unsigned CFG_FWD_BIT  = 8;
    localparam int unsigned CFG_W        = 16;

    localparam int unsigned NFFT_MIN_LOG2_DFLT = 3;
    localparam int unsigned NFFT_MAX_LOG2_DFLT = 10;

    function automatic logic [CFG_NFFT_W-1:0] clamp_log2(logic [CFG_NFFT_W-1:0] v,
                                                         int unsigned lo, int unsigned hi);
        if (32'(v) < lo) return CFG_NFFT_W'(lo);
        if (32'(v) > hi) return CFG_NFFT_W'(hi);
        return v;
    endfunction

    function automatic logic [CFG_W-1:0] cfg_word(logic [CFG_NFFT_W-1:0] nfft, logic fwd);
        logic [CFG_W-1:0] w;
        w = '0;
        w[CFG_NFFT_LSB +: CFG_NFFT_W] = nfft;
        w[CFG_FWD_BIT] = fwd;
        return w;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_beat_counter.sv
// Beat counter with a programmable power-of-two frame length and a last-beat flag.
module fft_beat_counter
    import fft_seq_pkg::*;
#(
    parameter int unsigned MaxLog2 = NFFT_MAX_LOG2_DFLT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [CFG_NFFT_W-1:0] len_log2_i,
    output logic                  last_o
);

    localparam int unsigned CntW = MaxLog2 + 1;

    logic [MaxLog2-1:0] beat_q;
    logic [CntW-1:0]    full_len;

    // Length is clamped upstream, so it never exceeds 1 << MaxLog2.
    assign full_len = CntW'(1) << len_log2_i;
    assign last_o   = (({1'b0, beat_q} + CntW'(1)) == full_len);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else if (clr_i) begin
            beat_q <= '0;
        end else if (en_i) begin
            beat_q <= last_o ? '0 : beat_q + MaxLog2'(1);
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Run-level controller: configures the FFT core, gates frames into it and drains its output.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned NFFT_MAX_LOG2 = NFFT_MAX_LOG2_DFLT,
    parameter int unsigned NFFT_MIN_LOG2 = NFFT_MIN_LOG2_DFLT,
    parameter int unsigned FRAME_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   fwd_inv,
    input  logic [4:0]             nfft_log2,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   stop,
    input  logic [DATA_W-1:0]      src_tdata,
    input  logic                   src_tvalid,
    output logic                   src_tready,
    output logic [15:0]            cfg_tdata,
    output logic                   cfg_tvalid,
    input  logic                   cfg_tready,
    output logic [DATA_W-1:0]      fft_tdata,
    output logic                   fft_tvalid,
    input  logic                   fft_tready,
    output logic                   fft_tlast,
    input  logic                   fft_out_tvalid,
    input  logic                   fft_out_tready,
    input  logic                   fft_out_tlast,
    input  logic                   event_tlast_unexpected,
    input  logic                   event_tlast_missing,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [FRAME_CNT_W-1:0] frames_in,
    output logic [FRAME_CNT_W-1:0] frames_out
);

    localparam int unsigned FcW1 = FRAME_CNT_W + 1;

    seq_state_e             state_q;
    logic                   fwd_q, stop_pending_q, busy_q, done_q, err_q;
    logic [CFG_NFFT_W-1:0]  nfft_q;
    logic [FRAME_CNT_W-1:0] num_frames_q, frames_in_q, frames_out_q, frames_in_nxt;
    logic [FRAME_CNT_W:0]   frames_in_inc;
    logic in_stream, in_cfg, start_acc, fft_hs, beat_last, frame_in_done, out_frame, last_frame;

    assign in_stream = (state_q == StStream);
    assign in_cfg    = (state_q == StCfg);
    assign start_acc = (state_q == StIdle) && start;

    assign fft_tdata  = in_stream ? src_tdata : '0;
    assign fft_tvalid = in_stream & src_tvalid;
    assign src_tready = in_stream & fft_tready;
    assign fft_hs     = fft_tvalid & fft_tready;
    assign fft_tlast  = in_stream & beat_last;
    assign cfg_tvalid = in_cfg;
    assign cfg_tdata  = in_cfg ? cfg_word(nfft_q, fwd_q) : '0;

    assign frame_in_done = fft_hs & beat_last;
    assign out_frame     = fft_out_tvalid & fft_out_tready & fft_out_tlast & (state_q != StIdle);
    assign frames_in_inc = {1'b0, frames_in_q} + FcW1'(1);
    assign last_frame    = (num_frames_q != '0) && (frames_in_inc == {1'b0, num_frames_q});
    assign frames_in_nxt = (frame_in_done && !(&frames_in_q)) ? frames_in_inc[FRAME_CNT_W-1:0]
                                                               : frames_in_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign frames_in  = frames_in_q;
    assign frames_out = frames_out_q;

    fft_beat_counter #(
        .MaxLog2(NFFT_MAX_LOG2)
    ) u_beat_counter (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (start_acc),
        .en_i      (fft_hs),
        .len_log2_i(nfft_q),
        .last_o    (beat_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            fwd_q          <= 1'b0;
            nfft_q         <= '0;
            num_frames_q   <= '0;
            frames_in_q    <= '0;
            frames_out_q   <= '0;
            stop_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            frames_in_q <= frames_in_nxt;
            if (out_frame && !(&frames_out_q)) frames_out_q <= frames_out_q + FRAME_CNT_W'(1);
            if ((state_q != StIdle) && (event_tlast_unexpected || event_tlast_missing)) begin
                err_q <= 1'b1;
            end
            // An output frame with no submitted frame left to account for is an error.
            if (out_frame && (frames_out_q >= frames_in_nxt)) err_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        fwd_q          <= fwd_inv;
                        nfft_q         <= clamp_log2(nfft_log2, NFFT_MIN_LOG2, NFFT_MAX_LOG2);
                        num_frames_q   <= num_frames;
                        frames_in_q    <= '0;
                        frames_out_q   <= '0;
                        err_q          <= 1'b0;
                        stop_pending_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= StCfg;
                    end
                end
                StCfg: begin
                    if (stop) stop_pending_q <= 1'b1;
                    if (cfg_tready) state_q <= (stop_pending_q || stop) ? StDrain : StStream;
                end
                StStream: begin
                    if (stop) stop_pending_q <= 1'b1;
                    if (frame_in_done && (last_frame || stop_pending_q || stop)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (frames_out_q >= frames_in_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a trivial FFT-core output model.
module tb_fft_frame_sequencer;

    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst, start, fwd_inv, stop, src_tvalid, src_tready, cfg_tvalid, cfg_tready;
    logic [4:0] nfft_log2;
    logic [15:0] num_frames, cfg_tdata, frames_in, frames_out;
    logic [DATA_W-1:0] src_tdata, fft_tdata;
    logic fft_tvalid, fft_tready, fft_tlast, fft_out_tvalid, fft_out_tready, fft_out_tlast;
    logic event_tlast_unexpected, event_tlast_missing, busy, done, err;

    always #5 clk = ~clk;

    fft_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .fwd_inv(fwd_inv), .nfft_log2(nfft_log2),
        .num_frames(num_frames), .stop(stop), .src_tdata(src_tdata), .src_tvalid(src_tvalid),
        .src_tready(src_tready), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
        .cfg_tready(cfg_tready), .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid),
        .fft_tready(fft_tready), .fft_tlast(fft_tlast), .fft_out_tvalid(fft_out_tvalid),
        .fft_out_tready(fft_out_tready), .fft_out_tlast(fft_out_tlast),
        .event_tlast_unexpected(event_tlast_unexpected),
        .event_tlast_missing(event_tlast_missing), .busy(busy), .done(done), .err(err),
        .frames_in(frames_in), .frames_out(frames_out)
    );

    int n_checks, n_fail;
    int nbeats, tl_count, cfg_hs, done_cnt, out_pend, bad;
    int stop_beat = -1, evt_beat = -1, abort_beat = -1;
    bit bp_mode, timeout, err_seen, cfg_rdy;
    logic [15:0] cfg_word;
    logic [DATA_W-1:0] base_data, next_data;
    logic [DATA_W-1:0] cap [0:2047];
    bit tl [0:2047];

    task automatic clear_log(input logic [DATA_W-1:0] base);
        nbeats = 0; tl_count = 0; cfg_hs = 0; done_cnt = 0; out_pend = 0;
        timeout = 0; err_seen = 0; cfg_word = '0;
        base_data = base; next_data = base;
        for (int i = 0; i < 2048; i++) tl[i] = 0;
    endtask

    task automatic start_run(input logic [4:0] n, input logic f, input logic [15:0] nf,
                             input logic s);
        @(negedge clk);
        start = 1'b1; nfft_log2 = n; fwd_inv = f; num_frames = nf; stop = s;
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step();
        @(negedge clk);
        start      = 1'b0;
        cfg_tready = cfg_rdy;
        src_tvalid = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        fft_tready = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        src_tdata  = next_data;
        stop       = (stop_beat >= 0) && (nbeats == stop_beat);
        event_tlast_missing = (evt_beat >= 0) && (nbeats == evt_beat);
        if (out_pend > 0) begin
            {fft_out_tvalid, fft_out_tready, fft_out_tlast} = 3'b111;
            out_pend--;
        end else begin
            {fft_out_tvalid, fft_out_tready, fft_out_tlast} = 3'b000;
        end
        #1;
        if (cfg_tvalid && cfg_tready) begin cfg_hs++; cfg_word = cfg_tdata; end
        if (fft_tvalid && fft_tready) begin
            if (nbeats < 2048) begin cap[nbeats] = fft_tdata; tl[nbeats] = fft_tlast; end
            if (fft_tlast) begin tl_count++; out_pend++; end
            nbeats++;
        end
        if (src_tvalid && src_tready) next_data = next_data + 1;
        if (done) done_cnt++;
        if (err) err_seen = 1;
    endtask

    task automatic run(input int max_cycles);
        int extra = -1;
        for (int c = 0; c < max_cycles; c++) begin
            step();
            if (abort_beat >= 0 && nbeats >= abort_beat) return;
            if (extra > 0) begin
                extra--;
                if (extra == 0) return;
            end else if (done) begin
                extra = 3;
            end
        end
        timeout = 1;
    endtask

    task automatic count_bad_data();
        bad = 0;
        for (int i = 0; i < nbeats && i < 2048; i++) if (cap[i] !== base_data + 32'(i)) bad++;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; fwd_inv = 0; nfft_log2 = 0; num_frames = 0; stop = 0;
        src_tdata = 0; src_tvalid = 0; cfg_tready = 0; fft_tready = 0; fft_out_tvalid = 0;
        fft_out_tready = 0; fft_out_tlast = 0; event_tlast_unexpected = 0;
        event_tlast_missing = 0; cfg_rdy = 1;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, err, cfg_tvalid, fft_tvalid, src_tready, fft_tlast} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, done, err, cfg_tvalid, fft_tvalid, src_tready, fft_tlast});
        end
        n_checks++;
        if ({frames_in, frames_out, cfg_tdata} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h want 0", {frames_in, frames_out, cfg_tdata});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_log(32'h1000_0000);
        start_run(5'd3, 1'b1, 16'd1, 1'b0);
        step();
        n_checks++;
        if (busy !== 1'b1 || cfg_tvalid !== 1'b1 || cfg_tdata !== 16'h0103) begin
            n_fail++;
            $display("FAIL single_cfg: got busy=%b valid=%b data=%h want 1 1 0103",
                     busy, cfg_tvalid, cfg_tdata);
        end
        run(200);
        count_bad_data();
        n_checks++;
        if (timeout || cfg_hs !== 1 || cfg_word !== 16'h0103) begin
            n_fail++;
            $display("FAIL single_cfg_hs: got to=%0d hs=%0d word=%h want 0 1 0103",
                     timeout, cfg_hs, cfg_word);
        end
        n_checks++;
        if (nbeats !== 8 || tl_count !== 1 || tl[7] !== 1'b1 || bad !== 0) begin
            n_fail++;
            $display("FAIL single_beats: got n=%0d tl=%0d tl7=%b bad=%0d want 8 1 1 0",
                     nbeats, tl_count, tl[7], bad);
        end
        n_checks++;
        if (done_cnt !== 1 || frames_in !== 16'd1 || frames_out !== 16'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%0d fi=%0d fo=%0d busy=%b want 1 1 1 0",
                     done_cnt, frames_in, frames_out, busy);
        end
    endtask

    task automatic test_backpressure();
        clear_log(32'h2000_0000);
        bp_mode = 1;
        start_run(5'd4, 1'b0, 16'd2, 1'b0);
        run(600);
        bp_mode = 0;
        count_bad_data();
        n_checks++;
        if (timeout || nbeats !== 32 || bad !== 0) begin
            n_fail++;
            $display("FAIL bp_data: got to=%0d n=%0d bad=%0d want 0 32 0", timeout, nbeats, bad);
        end
        n_checks++;
        if (tl_count !== 2 || tl[15] !== 1'b1 || tl[31] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_tlast: got cnt=%0d tl15=%b tl31=%b want 2 1 1",
                     tl_count, tl[15], tl[31]);
        end
        n_checks++;
        if (frames_in !== 16'd2 || done_cnt !== 1 || cfg_word !== 16'h0004) begin
            n_fail++;
            $display("FAIL bp_frames: got fi=%0d done=%0d cfg=%h want 2 1 0004",
                     frames_in, done_cnt, cfg_word);
        end
    endtask

    task automatic test_stop_mid_frame();
        clear_log(32'h3000_0000);
        stop_beat = 21;
        start_run(5'd3, 1'b1, 16'd0, 1'b0);
        run(300);
        stop_beat = -1;
        count_bad_data();
        n_checks++;
        if (timeout || nbeats !== 24 || tl_count !== 3 || tl[23] !== 1'b1 || bad !== 0) begin
            n_fail++;
            $display("FAIL stop_beats: got to=%0d n=%0d tl=%0d tl23=%b bad=%0d want 0 24 3 1 0",
                     timeout, nbeats, tl_count, tl[23], bad);
        end
        n_checks++;
        if (frames_in !== 16'd3 || frames_out !== 16'd3 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL stop_frames: got fi=%0d fo=%0d done=%0d want 3 3 1",
                     frames_in, frames_out, done_cnt);
        end
    endtask

    task automatic test_stop_in_cfg();
        clear_log(32'h4000_0000);
        cfg_rdy = 0;
        stop_beat = 0;
        start_run(5'd3, 1'b1, 16'd0, 1'b0);
        repeat (3) step();
        n_checks++;
        if (cfg_tvalid !== 1'b1 || cfg_tdata !== 16'h0103) begin
            n_fail++;
            $display("FAIL cfgstop_hold: got valid=%b data=%h want 1 0103", cfg_tvalid, cfg_tdata);
        end
        cfg_rdy = 1;
        run(100);
        stop_beat = -1;
        n_checks++;
        if (timeout || cfg_hs !== 1 || nbeats !== 0 || frames_in !== 16'd0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL cfgstop_end: got to=%0d hs=%0d n=%0d fi=%0d done=%0d want 0 1 0 0 1",
                     timeout, cfg_hs, nbeats, frames_in, done_cnt);
        end
    endtask

    task automatic test_start_with_stop();
        clear_log(32'h5000_0000);
        start_run(5'd3, 1'b0, 16'd1, 1'b1);
        run(200);
        n_checks++;
        if (timeout || nbeats !== 8 || frames_in !== 16'd1 || cfg_word !== 16'h0003) begin
            n_fail++;
            $display("FAIL startstop: got to=%0d n=%0d fi=%0d cfg=%h want 0 8 1 0003",
                     timeout, nbeats, frames_in, cfg_word);
        end
    endtask

    task automatic test_clamp();
        clear_log(32'h6000_0000);
        start_run(5'd12, 1'b0, 16'd1, 1'b0);
        run(1500);
        n_checks++;
        if (timeout || cfg_word !== 16'h000A || nbeats !== 1024 || tl_count !== 1
            || tl[1023] !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_hi: got to=%0d cfg=%h n=%0d tl=%0d tl1023=%b want 0 000a 1024 1 1",
                     timeout, cfg_word, nbeats, tl_count, tl[1023]);
        end
        clear_log(32'h7000_0000);
        start_run(5'd1, 1'b1, 16'd1, 1'b0);
        run(200);
        n_checks++;
        if (timeout || cfg_word !== 16'h0103 || nbeats !== 8 || tl[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_lo: got to=%0d cfg=%h n=%0d tl7=%b want 0 0103 8 1",
                     timeout, cfg_word, nbeats, tl[7]);
        end
    endtask

    task automatic test_error();
        clear_log(32'h8000_0000);
        evt_beat = 3;
        start_run(5'd3, 1'b1, 16'd2, 1'b0);
        run(300);
        evt_beat = -1;
        n_checks++;
        if (timeout || err !== 1'b1 || done_cnt !== 1 || frames_in !== 16'd2) begin
            n_fail++;
            $display("FAIL err_sticky: got to=%0d err=%b done=%0d fi=%0d want 0 1 1 2",
                     timeout, err, done_cnt, frames_in);
        end
        clear_log(32'h9000_0000);
        start_run(5'd3, 1'b1, 16'd1, 1'b0);
        step();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b busy=%b want 0 1", err, busy);
        end
        run(200);
        n_checks++;
        if (timeout || err_seen !== 1'b0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL err_clean_run: got to=%0d err=%b done=%0d want 0 0 1",
                     timeout, err_seen, done_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        clear_log(32'hA000_0000);
        abort_beat = 4;
        start_run(5'd3, 1'b1, 16'd1, 1'b0);
        run(100);
        abort_beat = -1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (nbeats !== 4 || {busy, done, err, cfg_tvalid, fft_tvalid, src_tready, fft_tlast} !== 7'b0
            || frames_in !== 16'd0 || fft_tdata !== '0) begin
            n_fail++;
            $display("FAIL midreset: got n=%0d flags=%b fi=%0d data=%h want 4 0000000 0 0",
                     nbeats, {busy, done, err, cfg_tvalid, fft_tvalid, src_tready, fft_tlast},
                     frames_in, fft_tdata);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_log(32'hB000_0000);
        start_run(5'd3, 1'b1, 16'd1, 1'b0);
        run(200);
        count_bad_data();
        n_checks++;
        if (timeout || cfg_hs !== 1 || nbeats !== 8 || tl_count !== 1 || tl[7] !== 1'b1
            || bad !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL midreset_rerun: got to=%0d hs=%0d n=%0d tl=%0d tl7=%b bad=%0d done=%0d want 0 1 8 1 1 0 1",
                     timeout, cfg_hs, nbeats, tl_count, tl[7], bad, done_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        bp_mode = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_stop_mid_frame();
        test_stop_in_cfg();
        test_start_with_stop();
        test_clamp();
        test_error();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
